// File: rtl/sum_gather_8.sv
// Collects up to eight stream words into a vector for an 8-input sum step.
// One vector can wait in the collection register while the output slot is busy.
module sum_gather_8 #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [LEN-1:0] in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [LEN-1:0] w_0,
    output logic [LEN-1:0] w_1,
    output logic [LEN-1:0] w_2,
    output logic [LEN-1:0] w_3,
    output logic [LEN-1:0] w_4,
    output logic [LEN-1:0] w_5,
    output logic [LEN-1:0] w_6,
    output logic [LEN-1:0] w_7,
    output logic [3:0]     out_count,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [7:0][LEN-1:0] coll_q, coll_d;
    logic [7:0][LEN-1:0] out_q, out_d;
    logic [7:0][LEN-1:0] vec;
    logic [2:0]          idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [3:0]          pend_cnt_q, pend_cnt_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                valid_q, valid_d;

    logic accept;
    logic close;
    logic slot_free;

    assign accept    = in_valid & ~pending_q;
    assign close     = accept & (in_last | (idx_q == 3'd7));
    assign slot_free = ~valid_q | out_ready;

    // Completed vector as it would look if the current word closes it:
    // earlier lanes from the collection register, the closing word, zeros above.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_vec
            localparam logic [2:0] LANE = 3'(gi);
            assign vec[gi] = (LANE < idx_q)  ? coll_q[gi] :
                             (LANE == idx_q) ? in_data    : '0;
        end
    endgenerate

    always_comb begin
        coll_d     = coll_q;
        out_d      = out_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        pend_cnt_d = pend_cnt_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;

        if (accept && !close) begin
            coll_d[idx_q] = in_data;
            idx_d         = idx_q + 3'd1;
        end

        if (close) begin
            idx_d = 3'd0;
            if (slot_free) begin
                out_d   = vec;
                cnt_d   = {1'b0, idx_q} + 4'd1;
                valid_d = 1'b1;
            end else begin
                coll_d     = vec;
                pend_cnt_d = {1'b0, idx_q} + 4'd1;
                pending_d  = 1'b1;
            end
        end else if (pending_q && slot_free) begin
            out_d     = coll_q;
            cnt_d     = pend_cnt_q;
            valid_d   = 1'b1;
            pending_d = 1'b0;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q     <= '0;
            out_q      <= '0;
            idx_q      <= 3'd0;
            pending_q  <= 1'b0;
            pend_cnt_q <= 4'd0;
            cnt_q      <= 4'd0;
            valid_q    <= 1'b0;
        end else begin
            coll_q     <= coll_d;
            out_q      <= out_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
        end
    end

    assign in_ready  = ~pending_q;
    assign out_valid = valid_q;
    assign out_count = cnt_q;
    assign w_0       = out_q[0];
    assign w_1       = out_q[1];
    assign w_2       = out_q[2];
    assign w_3       = out_q[3];
    assign w_4       = out_q[4];
    assign w_5       = out_q[5];
    assign w_6       = out_q[6];
    assign w_7       = out_q[7];

endmodule

// File: tb/tb_sum_gather_8.sv
// Self-checking bench for sum_gather_8: vector table plus backpressure,
// throughput and reset sequences, with a scoreboard of expected vectors.
module tb_sum_gather_8;

    typedef struct packed {
        logic [7:0][31:0] words;
        logic [3:0]       n;
        logic [7:0][31:0] exp_w;
        logic [3:0]       exp_cnt;
        logic [35:0]      exp_sum;
    } vec_t;

    typedef struct packed {
        logic [7:0][31:0] w;
        logic [3:0]       cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] w_0, w_1, w_2, w_3, w_4, w_5, w_6, w_7;
    logic [3:0]  out_count;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [7:0][31:0] wv;
    assign wv = {w_7, w_6, w_5, w_4, w_3, w_2, w_1, w_0};

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   cons_cyc[$];
    vec_t tbl[5];

    sum_gather_8 #(.LEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .w_0(w_0), .w_1(w_1), .w_2(w_2), .w_3(w_3),
        .w_4(w_4), .w_5(w_5), .w_6(w_6), .w_7(w_7),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: consume check against the scoreboard, and hold-stability check.
    logic             hold_prev = 1'b0;
    logic [7:0][31:0] prev_w;
    logic [3:0]       prev_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (!out_valid || wv !== prev_w || out_count !== prev_cnt) begin
                    failures++;
                    $display("FAIL hold valid=%0b cnt=%0d w0=%0h required cnt=%0d w0=%0h",
                             out_valid, out_count, wv[0], prev_cnt, prev_w[0]);
                end
            end
            if (out_valid && out_ready) begin
                exp_t e;
                checks++;
                cons_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL vector unexpected cnt=%0d w=%h", out_count, wv);
                end else begin
                    e = sb.pop_front();
                    if (wv !== e.w || out_count !== e.cnt) begin
                        failures++;
                        $display("FAIL vector actual cnt=%0d w=%h required cnt=%0d w=%h",
                                 out_count, wv, e.cnt, e.w);
                    end else begin
                        $display("vector ok cnt=%0d w=%h", out_count, wv);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_w    = wv;
            prev_cnt  = out_count;
        end
    end

    // Inputs are driven 1 time unit after a rising edge; returns 1 after the accept edge.
    task automatic send(input logic [31:0] d, input logic l, output bit stalled);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        stalled  = 1'b0;
        for (int t = 0; t < 200 && !in_ready; t++) begin
            stalled = 1'b1;
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual in_ready=0 required in_ready=1");
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic stop();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0][31:0] w, input logic [3:0] cnt);
        exp_t e;
        e.w   = w;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               st;
        int               stalls;
        logic [35:0]      sum;
        logic [7:0][31:0] w;

        for (int i = 0; i < 5; i++) tbl[i] = '0;
        for (int i = 0; i < 8; i++) begin
            tbl[0].words[i] = 32'(i + 1);
            tbl[0].exp_w[i] = 32'(i + 1);
            tbl[4].words[i] = 32'h8000_0000;
            tbl[4].exp_w[i] = 32'h8000_0000;
        end
        tbl[0].n = 8; tbl[0].exp_cnt = 8; tbl[0].exp_sum = 36'd36;
        tbl[1].words[0] = 5; tbl[1].words[1] = 6; tbl[1].words[2] = 7;
        tbl[1].exp_w[0] = 5; tbl[1].exp_w[1] = 6; tbl[1].exp_w[2] = 7;
        tbl[1].n = 3; tbl[1].exp_cnt = 3; tbl[1].exp_sum = 36'd18;
        tbl[2].words[0] = 32'hFFFF_FFFF; tbl[2].exp_w[0] = 32'hFFFF_FFFF;
        tbl[2].n = 1; tbl[2].exp_cnt = 1; tbl[2].exp_sum = 36'h0_FFFF_FFFF;
        tbl[3].words[0] = 32'hA5A5_A5A5; tbl[3].words[1] = 32'h5A5A_5A5A;
        tbl[3].words[2] = 32'h1234_5678; tbl[3].words[3] = 32'h8765_4321;
        tbl[3].exp_w[0] = 32'hA5A5_A5A5; tbl[3].exp_w[1] = 32'h5A5A_5A5A;
        tbl[3].exp_w[2] = 32'h1234_5678; tbl[3].exp_w[3] = 32'h8765_4321;
        tbl[3].n = 4; tbl[3].exp_cnt = 4; tbl[3].exp_sum = 36'h1_9999_9998;
        tbl[4].n = 8; tbl[4].exp_cnt = 8; tbl[4].exp_sum = 36'h4_0000_0000;

        // Reset state
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_w0", 64'(w_0), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_exp(tbl[i].exp_w, tbl[i].exp_cnt);
            for (int j = 0; j < 8; j++) begin
                if (j < int'(tbl[i].n))
                    send(tbl[i].words[j], (j == int'(tbl[i].n) - 1) && (tbl[i].n < 8), st);
            end
            stop();
            check($sformatf("tbl%0d_latency", i), 64'(out_valid), 64'd1);
            check($sformatf("tbl%0d_count", i), 64'(out_count), 64'(tbl[i].exp_cnt));
            sum = '0;
            for (int k = 0; k < 8; k++) sum = sum + 36'(wv[k]);
            check($sformatf("tbl%0d_sum", i), 64'(sum), 64'(tbl[i].exp_sum));
            cycles(2);
            check($sformatf("tbl%0d_drop", i), 64'(out_valid), 64'd0);
        end

        // Backpressure: two vectors, the second one goes pending
        out_ready = 1'b0;
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < 8; k++) w[k] = 32'(101 + v * 8 + k);
            push_exp(w, 4'd8);
        end
        for (int i = 0; i < 16; i++) begin
            send(32'(101 + i), 1'b0, st);
            if (i == 7) begin
                check("bp_first_valid", 64'(out_valid), 64'd1);
                check("bp_first_w0", 64'(w_0), 64'd101);
            end
        end
        stop();
        check("bp_pending_in_ready", 64'(in_ready), 64'd0);
        check("bp_first_w7", 64'(w_7), 64'd108);
        cycles(2);
        check("bp_still_pending", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_second_w0", 64'(w_0), 64'd109);
        check("bp_second_w7", 64'(w_7), 64'd116);
        check("bp_second_count", 64'(out_count), 64'd8);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
        cycles(2);
        out_ready = 1'b1;
        cycles(2);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Throughput: 64 words back to back
        stalls = 0;
        cons_cyc.delete();
        for (int i = 0; i < 64; i++) begin
            w[i % 8] = 32'(1000 + i);
            if (i % 8 == 7) push_exp(w, 4'd8);
            send(32'(1000 + i), 1'b0, st);
            if (st) stalls++;
        end
        stop();
        cycles(3);
        check("tp_stalls", 64'(stalls), 64'd0);
        check("tp_vectors", 64'(cons_cyc.size()), 64'd8);
        for (int i = 1; i < cons_cyc.size(); i++)
            check($sformatf("tp_spacing%0d", i), 64'(cons_cyc[i] - cons_cyc[i-1]), 64'd8);

        // Reset mid-vector
        for (int i = 0; i < 3; i++) send(32'(200 + i), 1'b0, st);
        stop();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_w", 64'(|wv), 64'd0);
        check("arst_count", 64'(out_count), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) w[k] = 32'(300 + k);
        push_exp(w, 4'd8);
        for (int i = 0; i < 8; i++) send(32'(300 + i), 1'b0, st);
        stop();
        check("arst_new_valid", 64'(out_valid), 64'd1);
        cycles(3);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
